// File: rtl/dma_port_arbiter.sv
// dma_port_arbiter: shares one DMA memory port between NUM_REQ requesters that
// each use the level-held dma_req / dma_ack protocol. One grantee at a time,
// each tenure capped at MAX_BURST acked beats, round-robin priority rotation.
//
// Optional feature macro: DMA_ARB_FIXED_PRIO_EN
//   defined   -> fixed priority in IDLE (lowest set index wins), no rr pointer
//   undefined -> round-robin starting at rr_ptr (default)
//
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   req_i/we_i        per-requester dma_req / dma_we
//   addr_i/wdata_i    per-requester address / write data, 32 bits each, packed
//   ack_o             per-requester dma_ack (only the grantee can be acked)
//   rdata_o           mem_rdata broadcast to all requesters
//   mem_*             single memory-side DMA port (combinational forward path)
//   grant_valid       a tenure is active
//   grant_id          current or most recent grantee
module dma_port_arbiter #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned ID_W      = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ-1:0]         we_i,
  input  logic [32*NUM_REQ-1:0]      addr_i,
  input  logic [32*NUM_REQ-1:0]      wdata_i,
  output logic [NUM_REQ-1:0]         ack_o,
  output logic [31:0]                rdata_o,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  input  logic                       mem_ack,
  input  logic [31:0]                mem_rdata,
  output logic                       grant_valid,
  output logic [ID_W-1:0]            grant_id
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 8;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]        state_q,    state_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

  logic [ID_W-1:0]   winner_c;
  logic              busy_c;
  logic              gnt_req_c;
  logic              gnt_we_c;
  logic [DATA_W-1:0] gnt_addr_c;
  logic [DATA_W-1:0] gnt_wdata_c;
  logic              beat_c;

`ifdef DMA_ARB_FIXED_PRIO_EN
  // Fixed priority: lowest set index wins.
  always_comb begin : pick_winner
    winner_c = '0;
    for (int unsigned j = NUM_REQ; j > 0; j--) begin
      if (req_i[j-1]) winner_c = ID_W'(j - 1);
    end
  end
`else
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    rr_next_c;
  logic [NUM_REQ-1:0] req_rot_c;

  // Rotate requests so bit 0 is the rr_ptr position; the lowest set bit of the
  // rotated vector is the first requester at or after rr_ptr.
  assign req_rot_c = NUM_REQ'({req_i, req_i} >> rr_ptr_q);

  always_comb begin : pick_winner
    int unsigned rot_sum;
    rot_sum  = 0;
    winner_c = '0;
    for (int unsigned j = NUM_REQ; j > 0; j--) begin
      if (req_rot_c[j-1]) begin
        rot_sum  = 32'(rr_ptr_q) + (j - 1);
        winner_c = ID_W'((rot_sum >= NUM_REQ) ? (rot_sum - NUM_REQ) : rot_sum);
      end
    end
  end

  assign rr_next_c = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);
`endif

  assign busy_c = (state_q == BUSY);

  // Grantee's request-side signals.
  always_comb begin : grantee_mux
    gnt_req_c   = 1'b0;
    gnt_we_c    = 1'b0;
    gnt_addr_c  = '0;
    gnt_wdata_c = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_id_q == ID_W'(k)) begin
        gnt_req_c   = req_i[k];
        gnt_we_c    = we_i[k];
        gnt_addr_c  = addr_i[DATA_W*k +: DATA_W];
        gnt_wdata_c = wdata_i[DATA_W*k +: DATA_W];
      end
    end
  end

  // A beat only counts while the grantee still drives its request.
  assign beat_c = busy_c & gnt_req_c & mem_ack;

  // Zero-latency forward path; everything is zero outside BUSY.
  assign mem_req   = busy_c & gnt_req_c;
  assign mem_we    = busy_c & gnt_we_c;
  assign mem_addr  = busy_c ? gnt_addr_c  : '0;
  assign mem_wdata = busy_c ? gnt_wdata_c : '0;
  assign rdata_o   = mem_rdata;

  always_comb begin : ack_route
    ack_o = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_id_q == ID_W'(k)) ack_o[k] = beat_c;
    end
  end

  assign grant_valid = busy_c;
  assign grant_id    = grant_id_q;

  // Next-state: grant in IDLE, count and release in BUSY.
  always_comb begin : next_state
    state_d    = state_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
`ifndef DMA_ARB_FIXED_PRIO_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d    = BUSY;
          grant_id_d = winner_c;
          beat_cnt_d = '0;
        end
      end
      BUSY: begin
        if (beat_c) beat_cnt_d = beat_cnt_q + CNT_W'(1);
        // Release on request drop, or after acking the capping beat.
        if (!gnt_req_c || (beat_c && (beat_cnt_q == CNT_W'(MAX_BURST - 1)))) begin
          state_d = IDLE;
`ifndef DMA_ARB_FIXED_PRIO_EN
          rr_ptr_d = rr_next_c;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
`ifndef DMA_ARB_FIXED_PRIO_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
`ifndef DMA_ARB_FIXED_PRIO_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_dma_port_arbiter.sv
// Randomized scoreboard bench for dma_port_arbiter. A tenure-level model
// predicts every cycle's outputs; a monitor compares them on the falling edge.
module tb_dma_port_arbiter;

  localparam int unsigned NR   = 3;
  localparam int unsigned MB   = 5;
  localparam int unsigned IDW  = 2;
  localparam int unsigned NCYC = 3000;

  typedef struct packed {
    logic [NR-1:0]  ack;
    logic           mreq;
    logic           mwe;
    logic [31:0]    maddr;
    logic [31:0]    mwdata;
    logic [31:0]    rdata;
    logic           gv;
    logic [IDW-1:0] gid;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req, we;
  logic [32*NR-1:0]  addr_bus, wdata_bus;
  logic [NR-1:0]     ack_o;
  logic [31:0]       rdata_o;
  logic              mem_req, mem_we, mem_ack;
  logic [31:0]       mem_addr, mem_wdata, mem_rdata;
  logic              grant_valid;
  logic [IDW-1:0]    grant_id;

  always #5 clk = ~clk;

  dma_port_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB), .ID_W(IDW)) dut (
    .clk(clk), .reset(reset), .req_i(req), .we_i(we), .addr_i(addr_bus),
    .wdata_i(wdata_bus), .ack_o(ack_o), .rdata_o(rdata_o), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .grant_valid(grant_valid),
    .grant_id(grant_id)
  );

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb_q[$];

  // Tenure-level reference: who owns the port, beats used, where search starts.
  bit          m_busy;
  int unsigned m_owner, m_used, m_next;
  int unsigned rem[NR];
  logic [31:0] cur_addr[NR];
  logic [31:0] cur_wdata[NR];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned pick(input logic [NR-1:0] r);
    int unsigned w;
    bit found;
    w = 0;
    found = 0;
`ifdef DMA_ARB_FIXED_PRIO_EN
    for (int unsigned i = 0; i < NR; i++)
      if (!found && r[i]) begin w = i; found = 1; end
`else
    for (int unsigned off = 0; off < NR; off++)
      if (!found && r[(m_next + off) % NR]) begin w = (m_next + off) % NR; found = 1; end
`endif
    return w;
  endfunction

  // Advance the model across one rising edge using the inputs held there.
  task automatic model_step();
    bit beat;
    beat = m_busy && req[m_owner] && mem_ack;
    if (beat && rem[m_owner] > 0) rem[m_owner]--;
    if (!m_busy) begin
      if (req != '0) begin
        m_owner = pick(req);
        m_busy  = 1;
        m_used  = 0;
      end
    end else if (!req[m_owner]) begin
      m_busy = 0;
      m_next = (m_owner + 1) % NR;
    end else if (beat) begin
      m_used++;
      if (m_used == MB) begin
        m_busy = 0;
        m_next = (m_owner + 1) % NR;
      end
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    bit gr;
    gr       = m_busy && req[m_owner];
    e.gv     = m_busy;
    e.gid    = IDW'(m_owner);
    e.mreq   = gr;
    e.mwe    = m_busy ? we[m_owner] : 1'b0;
    e.maddr  = m_busy ? cur_addr[m_owner] : 32'h0;
    e.mwdata = m_busy ? cur_wdata[m_owner] : 32'h0;
    e.ack    = (gr && mem_ack) ? (NR'(1) << m_owner) : '0;
    e.rdata  = mem_rdata;
    return e;
  endfunction

  task automatic drive_random();
    for (int k = 0; k < NR; k++) begin
      if (rem[k] == 0 && $urandom_range(0, 5) == 0) rem[k] = $urandom_range(1, 12);
      else if (rem[k] > 0 && $urandom_range(0, 49) == 0) rem[k] = 0;
      req[k]       = (rem[k] != 0);
      we[k]        = 1'($urandom_range(0, 1));
      cur_addr[k]  = $urandom;
      cur_wdata[k] = $urandom;
      addr_bus[32*k +: 32]  = cur_addr[k];
      wdata_bus[32*k +: 32] = cur_wdata[k];
    end
    mem_ack   = ($urandom_range(0, 3) != 0);
    mem_rdata = $urandom;
  endtask

  // Monitor: pop one expectation per cycle and compare away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("ack_o",       32'(ack_o),       32'(e.ack));
        chk("mem_req",     32'(mem_req),     32'(e.mreq));
        chk("mem_we",      32'(mem_we),      32'(e.mwe));
        chk("mem_addr",    mem_addr,         e.maddr);
        chk("mem_wdata",   mem_wdata,        e.mwdata);
        chk("rdata_o",     rdata_o,          e.rdata);
        chk("grant_valid", 32'(grant_valid), 32'(e.gv));
        chk("grant_id",    32'(grant_id),    32'(e.gid));
      end
    end
  end

  // Stimulus: random requesters, random mem_ack, one async reset mid-burst.
  initial begin
    bit rst_done;
    exp_t e;
    rst_done  = 0;
    reset     = 1'b0;
    req       = '0;
    we        = '0;
    addr_bus  = '0;
    wdata_bus = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    m_busy = 0; m_owner = 0; m_used = 0; m_next = 0;
    for (int k = 0; k < NR; k++) begin
      rem[k] = 0; cur_addr[k] = '0; cur_wdata[k] = '0;
    end

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      if (reset) model_step();
      #1;
      if (cyc == 2) reset = 1'b1;
      drive_random();
      e = predict();
      sb_q.push_back(e);

      if (!rst_done && cyc > 1000 && e.mreq && m_used >= 2) begin
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_mem_req",     32'(mem_req),     32'h0);
        chk("rst_ack_o",       32'(ack_o),       32'h0);
        chk("rst_mem_addr",    mem_addr,         32'h0);
        chk("rst_grant_valid", 32'(grant_valid), 32'h0);
        chk("rst_grant_id",    32'(grant_id),    32'h0);
        m_busy = 0; m_owner = 0; m_used = 0; m_next = 0;
        #1 reset = 1'b1;
        rst_done = 1;
      end
    end

    repeat (3) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    n_checks++;
    if (!rst_done) begin
      n_errors++;
      $display("FAIL reset_inject: got 0 expected 1");
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
